mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 105 ++++++++++
 tb/tb_mem_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one fixed-latency single-ported memory between
// instruction fetch and the MEM stage. MEM has priority, with a starvation guard for IF.
module mem_arbiter #(
  parameter int LAT    = 2,
  parameter int STARVE = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_ack,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  output logic        mem_ack,
  output logic [15:0] m_addr,
  output logic [15:0] m_wdata,
  output logic        m_re,
  output logic        m_we,
  input  logic [15:0] m_rdata,
  output logic        hold
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM} state_t;

  state_t     state;
  logic [3:0] starve_cnt;
  logic [2:0] lat_cnt;
  logic       rd_op;
  logic       if_pend, mem_pend, if_win;

  // A port being acked this cycle is done; its still-high req is not a new request.
  assign if_pend  = if_req & ~if_ack;
  assign mem_pend = mem_req & ~mem_ack;
  assign hold     = if_pend | mem_pend;
  assign if_win   = if_pend & (~mem_pend | (starve_cnt == 4'(STARVE)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      lat_cnt    <= '0;
      rd_op      <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      m_re       <= 1'b0;
      m_we       <= 1'b0;
      if_ack     <= 1'b0;
      mem_ack    <= 1'b0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
    end else begin
      m_re    <= 1'b0;
      m_we    <= 1'b0;
      if_ack  <= 1'b0;
      mem_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (if_win) begin
            state      <= BUSY_IF;
            m_re       <= 1'b1;
            m_addr     <= if_addr;
            m_wdata    <= '0;
            rd_op      <= 1'b1;
            lat_cnt    <= 3'(LAT);
            starve_cnt <= '0;
          end else if (mem_pend) begin
            state   <= BUSY_MEM;
            m_re    <= ~mem_we;
            m_we    <= mem_we;
            m_addr  <= mem_addr;
            m_wdata <= mem_wdata;
            rd_op   <= ~mem_we;
            lat_cnt <= 3'(LAT);
            if (!if_pend)
              starve_cnt <= '0;
            else if (starve_cnt < 4'(STARVE))
              starve_cnt <= starve_cnt + 4'd1;
          end
        end
        BUSY_IF, BUSY_MEM: begin
          // The strobe cycle does not count toward the latency.
          if (!(m_re || m_we)) begin
            lat_cnt <= lat_cnt - 3'd1;
            if (lat_cnt == 3'd1) begin
              state <= IDLE;
              if (state == BUSY_IF) begin
                if_ack   <= 1'b1;
                if_rdata <= m_rdata;
              end else begin
                mem_ack <= 1'b1;
                if (rd_op) mem_rdata <= m_rdata;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: a transaction-level model schedules
// grants/acks, a memory responder answers strobes, and a monitor checks every cycle.
module tb_mem_arbiter;
  localparam int LAT    = 2;
  localparam int STARVE = 3;

  logic        clk = 1'b0, rst = 1'b0;
  logic        if_req = 1'b0, mem_req = 1'b0, mem_we = 1'b0;
  logic [15:0] if_addr = '0, mem_addr = '0, mem_wdata = '0, m_rdata = '0;
  logic [15:0] if_rdata, mem_rdata, m_addr, m_wdata;
  logic        if_ack, mem_ack, m_re, m_we, hold;

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter #(.LAT(LAT), .STARVE(STARVE)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_re(m_re), .m_we(m_we),
    .m_rdata(m_rdata), .hold(hold)
  );

  typedef struct {bit is_mem; bit is_wr; logic [15:0] addr; logic [15:0] wdata; logic [15:0] data; int ack_cyc;} txn_t;
  typedef struct {bit we; logic [15:0] addr; logic [15:0] wdata;} req_t;

  txn_t exp_q[$];
  req_t if_wq[$], mem_wq[$];
  logic [15:0] resp_mem [0:255];
  logic [15:0] ref_mem  [0:255];

  int checks = 0, errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory responder: data is valid only in the cycle LAT after the read strobe.
  int          rd_due = -1;
  logic [15:0] rd_val = '0;
  always @(posedge clk) begin
    #1;
    if (m_we) resp_mem[m_addr[7:0]] = m_wdata;
    if (m_re) begin
      rd_due = cyc + LAT;
      rd_val = resp_mem[m_addr[7:0]];
    end
    m_rdata = (cyc == rd_due) ? rd_val : 16'($urandom);
  end

  // Reference model state: the memory is busy from a grant until its ack cycle.
  int          free_cyc = 0, ack_port = -1, strobe_cyc = -1, starve = 0;
  int          if_ack_c = 0, mem_ack_c = 0;
  bit          if_out = 0, mem_out = 0, strobe_wr = 0;
  logic [15:0] strobe_addr = '0, strobe_wdata = '0;
  bit          exp_hold = 0, exp_re = 0, exp_we = 0;
  logic [15:0] exp_addr = '0, exp_wdata = '0;

  task automatic step();
    bit   pend_if, pend_mem, if_wins;
    req_t r;
    txn_t t;
    if (if_out && cyc > if_ack_c) begin if_out = 0; if_req = 0; end
    if (mem_out && cyc > mem_ack_c) begin mem_out = 0; mem_req = 0; end
    if (!if_out && if_wq.size() != 0) begin
      r = if_wq.pop_front();
      if_addr = r.addr; if_req = 1; if_out = 1; if_ack_c = 32'h7fffffff;
    end
    if (!mem_out && mem_wq.size() != 0) begin
      r = mem_wq.pop_front();
      mem_we = r.we; mem_addr = r.addr; mem_wdata = r.wdata; mem_req = 1; mem_out = 1;
      mem_ack_c = 32'h7fffffff;
    end
    pend_if  = if_req  && !(cyc == free_cyc && ack_port == 0);
    pend_mem = mem_req && !(cyc == free_cyc && ack_port == 1);
    exp_hold  = pend_if || pend_mem;
    exp_re    = (cyc == strobe_cyc) && !strobe_wr;
    exp_we    = (cyc == strobe_cyc) && strobe_wr;
    exp_addr  = strobe_addr;
    exp_wdata = strobe_wdata;
    if (cyc >= free_cyc && (pend_if || pend_mem)) begin
      if_wins   = pend_if && (!pend_mem || starve == STARVE);
      t.ack_cyc = cyc + LAT + 2;
      if (if_wins) begin
        t.is_mem = 0; t.is_wr = 0; t.addr = if_addr; t.wdata = '0;
        starve = 0; if_ack_c = t.ack_cyc; ack_port = 0;
      end else begin
        t.is_mem = 1; t.is_wr = mem_we; t.addr = mem_addr; t.wdata = mem_wdata;
        starve = pend_if ? ((starve < STARVE) ? starve + 1 : starve) : 0;
        mem_ack_c = t.ack_cyc; ack_port = 1;
      end
      t.data = ref_mem[t.addr[7:0]];
      if (t.is_wr) ref_mem[t.addr[7:0]] = t.wdata;
      free_cyc = t.ack_cyc; strobe_cyc = cyc + 1;
      strobe_wr = t.is_wr; strobe_addr = t.addr; strobe_wdata = t.wdata;
      exp_q.push_back(t);
    end
  endtask

  task automatic model_reset();
    exp_q.delete(); if_wq.delete(); mem_wq.delete();
    free_cyc = 0; ack_port = -1; strobe_cyc = -1; starve = 0;
    if_out = 0; mem_out = 0; if_req = 0; mem_req = 0;
    exp_hold = 0; exp_re = 0; exp_we = 0;
  endtask

  task automatic run(int n);
    repeat (n) begin
      @(posedge clk); #1;
      step();
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((if_out || mem_out || if_wq.size() != 0 || mem_wq.size() != 0) && n < 300) begin
      run(1); n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL drain timeout: requests still pending after %0d cycles", n);
    end
    run(2);
  endtask

  function automatic logic [15:0] rand_addr();
    return {8'($urandom), 8'($urandom_range(0, 15) * 8)};
  endfunction

  task automatic rand_reqs();
    req_t r;
    if (if_wq.size() == 0 && $urandom_range(0, 2) == 0) begin
      r.we = 0; r.addr = rand_addr(); r.wdata = '0;
      if_wq.push_back(r);
    end
    if (mem_wq.size() == 0 && $urandom_range(0, 2) == 0) begin
      r.we = 1'($urandom_range(0, 1)); r.addr = rand_addr(); r.wdata = 16'($urandom);
      mem_wq.push_back(r);
    end
  endtask

  // Monitor: pops the scoreboard on every ack and checks per-cycle outputs.
  logic [15:0] last_if = '0, last_mem = '0;
  txn_t        mon_t;
  always @(negedge clk) begin
    if (!rst) begin
      last_if = '0; last_mem = '0;
    end else begin
      if (if_ack && mem_ack) begin
        checks++; errors++;
        $display("FAIL ack exclusive: if_ack and mem_ack both high (cycle %0d)", cyc);
      end
      if (if_ack || mem_ack) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected ack: if_ack=%0b mem_ack=%0b, none expected (cycle %0d)", if_ack, mem_ack, cyc);
        end else begin
          mon_t = exp_q.pop_front();
          chk("ack port", 32'(mem_ack), 32'(mon_t.is_mem));
          chk("ack cycle", 32'(cyc), 32'(mon_t.ack_cyc));
          if (!mon_t.is_wr) begin
            if (mon_t.is_mem) last_mem = mon_t.data;
            else last_if = mon_t.data;
          end
        end
      end else if (exp_q.size() != 0 && exp_q[0].ack_cyc <= cyc) begin
        mon_t = exp_q.pop_front();
        checks++; errors++;
        $display("FAIL missing ack: no ack, expected %s ack at cycle %0d", mon_t.is_mem ? "mem" : "if", mon_t.ack_cyc);
      end
      chk("if_rdata", 32'(if_rdata), 32'(last_if));
      chk("mem_rdata", 32'(mem_rdata), 32'(last_mem));
      chk("hold", 32'(hold), 32'(exp_hold));
      chk("m_re", 32'(m_re), 32'(exp_re));
      chk("m_we", 32'(m_we), 32'(exp_we));
      if (exp_re || exp_we) chk("m_addr", 32'(m_addr), 32'(exp_addr));
      if (exp_we) chk("m_wdata", 32'(m_wdata), 32'(exp_wdata));
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      resp_mem[i] = 16'(i * 257) ^ 16'h3C3C;
      ref_mem[i]  = 16'(i * 257) ^ 16'h3C3C;
    end
    #1;
    chk("reset m_re", 32'(m_re), 0);
    chk("reset m_we", 32'(m_we), 0);
    chk("reset acks", 32'({if_ack, mem_ack}), 0);
    chk("reset m_addr", 32'(m_addr), 0);
    chk("reset rdata", 32'({if_rdata, mem_rdata}), 0);
    repeat (2) @(posedge clk);

    // IF read returning 0xBEEF from 0x0010, issued in the first cycle after reset.
    resp_mem[8'h10] = 16'hBEEF; ref_mem[8'h10] = 16'hBEEF;
    if_wq.push_back('{we: 1'b0, addr: 16'h0010, wdata: 16'h0000});
    @(posedge clk); #1;
    rst = 1;
    step();
    drain();

    // Simultaneous requests: MEM write goes first, IF follows back-to-back.
    mem_wq.push_back('{we: 1'b1, addr: 16'h0040, wdata: 16'h1234});
    if_wq.push_back('{we: 1'b0, addr: 16'h0020, wdata: 16'h0000});
    drain();
    mem_wq.push_back('{we: 1'b0, addr: 16'h0040, wdata: 16'h0000});
    drain();

    // A write after a read leaves mem_rdata at the read value.
    resp_mem[8'h50] = 16'hAAAA; ref_mem[8'h50] = 16'hAAAA;
    mem_wq.push_back('{we: 1'b0, addr: 16'h0050, wdata: 16'h0000});
    mem_wq.push_back('{we: 1'b1, addr: 16'h0050, wdata: 16'h5555});
    drain();

    // Both ports held busy continuously.
    for (int i = 0; i < 4; i++) begin
      mem_wq.push_back('{we: 1'(i & 1), addr: 16'(16'h0080 + i * 8), wdata: 16'(16'hC000 + i)});
      if (i < 2) if_wq.push_back('{we: 1'b0, addr: 16'(16'h0088 + i * 8), wdata: 16'h0000});
    end
    drain();

    for (int i = 0; i < 1500; i++) begin
      rand_reqs();
      run(1);
    end
    drain();

    // Reset during the second busy cycle of a MEM read.
    mem_wq.push_back('{we: 1'b0, addr: 16'h0060, wdata: 16'h0000});
    run(2);
    @(posedge clk); #2;
    rst = 0;
    model_reset();
    #1;
    chk("midreset m_re", 32'(m_re), 0);
    chk("midreset mem_ack", 32'(mem_ack), 0);
    chk("midreset mem_rdata", 32'(mem_rdata), 0);
    chk("midreset m_addr", 32'(m_addr), 0);
    @(posedge clk); #1;
    rst = 1;
    step();
    run(8);

    for (int i = 0; i < 500; i++) begin
      rand_reqs();
      run(1);
    end
    drain();
    run(LAT + 4);
    chk("scoreboard empty", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
